// File: rtl/line_clear_sequencer.sv
// Feeds a freshly locked board through the external row eliminator, one pass per cycle,
// then commits board, rows cleared, score and line total. Optional per-row flash: `define CLEAR_ANIM_EN.
module line_clear_sequencer #(
   parameter int COLS        = 10,
   parameter int ROWS        = 20,
   parameter int SCORE_W     = 20,
   parameter int ANIM_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   game_reset,
   input  logic                   lock_valid,
   output logic                   lock_ready,
   input  logic [ROWS*COLS-1:0]   lock_board,
   output logic [ROWS*COLS-1:0]   elim_static,
   input  logic                   elim_eliminated,
   input  logic [ROWS*COLS-1:0]   elim_new_static,
   output logic [ROWS*COLS-1:0]   board,
   output logic                   busy,
   output logic                   done,
   output logic [4:0]             rows_cleared,
   output logic [SCORE_W-1:0]     score,
   output logic [15:0]            total_lines,
   output logic                   error,
   output logic                   flash_active
);
   localparam int         N          = ROWS * COLS;
   localparam logic [4:0] PASS_LIMIT = 5'(ROWS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2,
      S_ANIM = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         work_q, work_d;
   logic [N-1:0]         board_q, board_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [4:0]           rows_q, rows_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [15:0]          lines_q, lines_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 commit;
   logic [10:0]          pts;
   logic [SCORE_W:0]     score_sum;
   logic [16:0]          lines_sum;

`ifdef CLEAR_ANIM_EN
   localparam int            AW        = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);
   logic [AW-1:0]            anim_q, anim_d;
`else
   logic unused_anim_cfg;
   assign unused_anim_cfg = ANIM_CYCLES[0];
`endif

   always_comb begin
      case (cnt_q)
         5'd0:    pts = 11'd0;
         5'd1:    pts = 11'd40;
         5'd2:    pts = 11'd100;
         5'd3:    pts = 11'd300;
         default: pts = 11'd1200;
      endcase
   end

   assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);
   assign lines_sum = {1'b0, lines_q} + 17'(cnt_q);

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      board_d = board_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      score_d = score_q;
      lines_d = lines_q;
      err_d   = err_q;
      commit  = 1'b0;
`ifdef CLEAR_ANIM_EN
      anim_d  = anim_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (lock_valid && !game_reset) begin
               work_d  = lock_board;
               cnt_d   = 5'd0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            // cnt_q doubles as the pass counter: every earlier SCAN cycle of this lock eliminated a row
            if (elim_eliminated && cnt_q >= PASS_LIMIT) begin
               err_d  = 1'b1;
               commit = 1'b1;
            end else if (elim_eliminated) begin
               work_d = elim_new_static;
               cnt_d  = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
`ifdef CLEAR_ANIM_EN
               anim_d  = '0;
               state_d = S_ANIM;
`endif
            end else begin
               commit = 1'b1;
            end
         end
`ifdef CLEAR_ANIM_EN
         S_ANIM: begin
            if (anim_q == ANIM_LAST) state_d = S_SCAN;
            else                     anim_d  = anim_q + 1'b1;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (commit) begin
         board_d = work_q;
         rows_d  = cnt_q;
         score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
         lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
         state_d = S_DONE;
      end
      done_d = commit;

      if (game_reset) begin
         state_d = S_IDLE;
         work_d  = '0;
         board_d = '0;
         cnt_d   = 5'd0;
         rows_d  = 5'd0;
         score_d = '0;
         lines_d = 16'd0;
         err_d   = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         board_q <= '0;
         cnt_q   <= 5'd0;
         rows_q  <= 5'd0;
         score_q <= '0;
         lines_q <= 16'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef CLEAR_ANIM_EN
         anim_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         board_q <= board_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
         score_q <= score_d;
         lines_q <= lines_d;
         err_q   <= err_d;
         done_q  <= done_d;
`ifdef CLEAR_ANIM_EN
         anim_q  <= anim_d;
`endif
      end
   end

   assign lock_ready   = (state_q == S_IDLE) && !game_reset;
   assign elim_static  = work_q;
   assign board        = board_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign rows_cleared = rows_q;
   assign score        = score_q;
   assign total_lines  = lines_q;
   assign error        = err_q;
`ifdef CLEAR_ANIM_EN
   assign flash_active = (state_q == S_ANIM);
`else
   assign flash_active = 1'b0;
`endif

endmodule
